// File: rtl/simd_isa_pkg.sv
// simd_isa_pkg
// Shared ISA definitions for the SIMD decode/issue stage and its register
// file: opcode and function constants, execute-unit / shift / lane-width
// encodings, the decoded-instruction record and the field decoder.
// No ports (package).

package simd_isa_pkg;

  localparam int DATA_W = 64;
  localparam int NREG   = 32;
  localparam int AW     = 5;

  localparam logic [5:0] OP_NOP   = 6'b000000;
  localparam logic [5:0] OP_RTYPE = 6'b101010;

  localparam logic [5:0] F_SLL  = 6'b000001;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;
  localparam logic [5:0] F_RTTH = 6'b000100;

  typedef enum logic [1:0] {
    UNIT_NOP = 2'b00,
    UNIT_SHF = 2'b01,
    UNIT_ALU = 2'b10
  } unit_e;

  typedef enum logic [1:0] {
    SH_SLL  = 2'b00,
    SH_SRL  = 2'b01,
    SH_SRA  = 2'b10,
    SH_RTTH = 2'b11
  } shift_e;

  typedef enum logic [1:0] {
    WW_BYTE   = 2'b00,
    WW_HALF   = 2'b01,
    WW_WORD   = 2'b10,
    WW_DOUBLE = 2'b11
  } ww_e;

  typedef struct packed {
    unit_e      unit;
    shift_e     shift;
    ww_e        ww;
    logic [5:0] func;
    logic [4:0] rd;
    logic       wr_en;
    logic       illegal;
  } dec_t;

  // Field decode. Non-R-type ops drive every field to zero so nothing
  // undefined leaks into the execute stage; undefined opcodes issue as NOP.
  function automatic dec_t decode(input logic [0:31] instr);
    dec_t       d;
    logic [5:0] op;
    logic [5:0] fn;
    op        = instr[0:5];
    fn        = instr[26:31];
    d.unit    = UNIT_NOP;
    d.shift   = SH_SLL;
    d.ww      = WW_BYTE;
    d.func    = 6'd0;
    d.rd      = 5'd0;
    d.wr_en   = 1'b0;
    d.illegal = 1'b0;
    case (op)
      OP_NOP: begin
        d.unit = UNIT_NOP;
      end
      OP_RTYPE: begin
        d.ww    = ww_e'(instr[24:25]);
        d.func  = fn;
        d.rd    = instr[6:10];
        d.wr_en = 1'b1;
        if (fn >= F_SLL && fn <= F_RTTH) begin
          d.unit  = UNIT_SHF;
          // func 1..4 map onto shift encodings 0..3 (func[4:5] minus one)
          d.shift = shift_e'(fn[1:0] - 2'd1);
        end else begin
          d.unit  = UNIT_ALU;
        end
      end
      default: begin
        d.illegal = 1'b1;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/simd_regfile.sv
// simd_regfile
// 32 x 64-bit register file: one synchronous write port, two combinational
// read ports with write-through bypass, synchronous active-high reset that
// clears every entry. r0 is an ordinary register.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   i_we/i_waddr/i_wdata  write port (commits on rising edge)
//   i_raddr_a/o_rdata_a   read port A
//   i_raddr_b/o_rdata_b   read port B

module simd_regfile
  import simd_isa_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_we,
  input  logic [0:AW-1]     i_waddr,
  input  logic [0:DATA_W-1] i_wdata,
  input  logic [0:AW-1]     i_raddr_a,
  output logic [0:DATA_W-1] o_rdata_a,
  input  logic [0:AW-1]     i_raddr_b,
  output logic [0:DATA_W-1] o_rdata_b
);

  logic [0:DATA_W-1] r_mem [0:NREG-1];

  // Storage; a write arriving in the reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        r_mem[i] <= {DATA_W{1'b0}};
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Write-through: a same-cycle write to the read address is returned directly.
  always_comb begin
    o_rdata_a = r_mem[i_raddr_a];
    if (i_we && (i_waddr == i_raddr_a)) begin
      o_rdata_a = i_wdata;
    end else begin
      o_rdata_a = r_mem[i_raddr_a];
    end
  end

  // Port B mirrors port A.
  always_comb begin
    o_rdata_b = r_mem[i_raddr_b];
    if (i_we && (i_waddr == i_raddr_b)) begin
      o_rdata_b = i_wdata;
    end else begin
      o_rdata_b = r_mem[i_raddr_b];
    end
  end

endmodule

// File: rtl/simd_decode_issue.sv
// simd_decode_issue
// Decode/issue stage feeding the SIMD shifter/ALU. Accepts instructions over
// a valid/ready handshake, decodes them, reads two operands (execute-result
// forwarding > writeback bypass > register file) and registers the result
// in the ID/EX register.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   if_valid/if_ready/if_instr      fetch handshake and instruction
//   wb_en/wb_addr/wb_data           register-file writeback
//   fwd_en/fwd_addr/fwd_data        execute-stage result forwarding
//   ex_ready/ex_valid               execute handshake
//   ex_unit/ex_shift/ex_ww/ex_func  decoded control
//   ex_ra/ex_rb                     operands
//   ex_rd/ex_wr_en                  destination
//   illegal                         sticky undefined-opcode flag

module simd_decode_issue
  import simd_isa_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [0:31]       if_instr,
  input  logic              wb_en,
  input  logic [0:AW-1]     wb_addr,
  input  logic [0:DATA_W-1] wb_data,
  input  logic              fwd_en,
  input  logic [0:AW-1]     fwd_addr,
  input  logic [0:DATA_W-1] fwd_data,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [0:1]        ex_unit,
  output logic [0:1]        ex_shift,
  output logic [0:1]        ex_ww,
  output logic [0:5]        ex_func,
  output logic [0:DATA_W-1] ex_ra,
  output logic [0:DATA_W-1] ex_rb,
  output logic [0:AW-1]     ex_rd,
  output logic              ex_wr_en,
  output logic              illegal
);

  dec_t              w_dec;
  logic              w_accept;
  logic [0:AW-1]     w_ra_addr;
  logic [0:AW-1]     w_rb_addr;
  logic [0:DATA_W-1] w_rf_a;
  logic [0:DATA_W-1] w_rf_b;
  logic [0:DATA_W-1] w_ra_val;
  logic [0:DATA_W-1] w_rb_val;

  logic              r_valid;
  logic [0:1]        r_unit;
  logic [0:1]        r_shift;
  logic [0:1]        r_ww;
  logic [0:5]        r_func;
  logic [0:DATA_W-1] r_ra;
  logic [0:DATA_W-1] r_rb;
  logic [0:AW-1]     r_rd;
  logic              r_wr_en;
  logic              r_illegal;

  assign if_ready  = !r_valid || ex_ready;
  assign w_accept  = if_valid && if_ready;
  assign w_ra_addr = if_instr[11:15];
  assign w_rb_addr = if_instr[16:20];

  simd_regfile u_regfile (
    .clk       (clk),
    .reset     (reset),
    .i_we      (wb_en),
    .i_waddr   (wb_addr),
    .i_wdata   (wb_data),
    .i_raddr_a (w_ra_addr),
    .o_rdata_a (w_rf_a),
    .i_raddr_b (w_rb_addr),
    .o_rdata_b (w_rf_b)
  );

  // Field decode of the presented instruction.
  always_comb begin
    w_dec = decode(if_instr);
  end

  // Execute-result forwarding takes priority over the regfile/wb-bypass value.
  always_comb begin
    w_ra_val = w_rf_a;
    w_rb_val = w_rf_b;
    if (fwd_en && (fwd_addr == w_ra_addr)) begin
      w_ra_val = fwd_data;
    end else begin
      w_ra_val = w_rf_a;
    end
    if (fwd_en && (fwd_addr == w_rb_addr)) begin
      w_rb_val = fwd_data;
    end else begin
      w_rb_val = w_rf_b;
    end
  end

  // ID/EX register: loads on accept, empties on a bubble, holds while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_unit  <= 2'b00;
      r_shift <= 2'b00;
      r_ww    <= 2'b00;
      r_func  <= 6'd0;
      r_ra    <= {DATA_W{1'b0}};
      r_rb    <= {DATA_W{1'b0}};
      r_rd    <= 5'd0;
      r_wr_en <= 1'b0;
    end else if (if_ready) begin
      r_valid <= w_accept;
      if (w_accept) begin
        r_unit  <= w_dec.unit;
        r_shift <= w_dec.shift;
        r_ww    <= w_dec.ww;
        r_func  <= w_dec.func;
        r_ra    <= w_ra_val;
        r_rb    <= w_rb_val;
        r_rd    <= w_dec.rd;
        r_wr_en <= w_dec.wr_en;
      end else begin
        r_wr_en <= r_wr_en;
      end
    end else begin
      r_valid <= r_valid;
    end
  end

  // Sticky undefined-opcode flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_illegal <= 1'b0;
    end else if (w_accept && w_dec.illegal) begin
      r_illegal <= 1'b1;
    end else begin
      r_illegal <= r_illegal;
    end
  end

  assign ex_valid = r_valid;
  assign ex_unit  = r_unit;
  assign ex_shift = r_shift;
  assign ex_ww    = r_ww;
  assign ex_func  = r_func;
  assign ex_ra    = r_ra;
  assign ex_rb    = r_rb;
  assign ex_rd    = r_rd;
  assign ex_wr_en = r_wr_en;
  assign illegal  = r_illegal;

endmodule

// File: tb/tb_simd_decode_issue.sv
// Self-checking bench for simd_decode_issue: a driver issues directed and
// random traffic, a behavioural model predicts each issued op into a queue,
// and a negedge monitor compares the ID/EX outputs against the queue head.

module tb_simd_decode_issue;

  typedef struct {
    logic [1:0]  unit;
    logic [1:0]  shift;
    logic [1:0]  ww;
    logic [5:0]  func;
    logic [63:0] ra;
    logic [63:0] rb;
    logic [4:0]  rd;
    logic        wr;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_valid = 1'b0;
  logic        if_ready;
  logic [0:31] if_instr = 32'd0;
  logic        wb_en = 1'b0;
  logic [0:4]  wb_addr = 5'd0;
  logic [0:63] wb_data = 64'd0;
  logic        fwd_en = 1'b0;
  logic [0:4]  fwd_addr = 5'd0;
  logic [0:63] fwd_data = 64'd0;
  logic        ex_ready = 1'b1;
  logic        ex_valid;
  logic [0:1]  ex_unit;
  logic [0:1]  ex_shift;
  logic [0:1]  ex_ww;
  logic [0:5]  ex_func;
  logic [0:63] ex_ra;
  logic [0:63] ex_rb;
  logic [0:4]  ex_rd;
  logic        ex_wr_en;
  logic        illegal;

  int n_checks = 0;
  int n_fail = 0;
  bit in_reset = 1'b1;

  exp_t        exp_q[$];
  logic [63:0] m_regs [32];
  bit          m_valid = 1'b0;
  bit          m_illegal = 1'b0;

  simd_decode_issue dut (
    .clk(clk), .reset(reset),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .fwd_en(fwd_en), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_unit(ex_unit),
    .ex_shift(ex_shift), .ex_ww(ex_ww), .ex_func(ex_func),
    .ex_ra(ex_ra), .ex_rb(ex_rb), .ex_rd(ex_rd), .ex_wr_en(ex_wr_en),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [0:31] mk(input int op, input int rd, input int ra,
                                     input int rb, input int ww, input int fn);
    logic [0:31] w;
    w = {op[5:0], rd[4:0], ra[4:0], rb[4:0], 3'b000, ww[1:0], fn[5:0]};
    return w;
  endfunction

  // Operand as the specification prioritises it: fwd, then wb, then storage.
  function automatic logic [63:0] src_val(input int a);
    if (fwd_en && int'(fwd_addr) == a) return fwd_data;
    if (wb_en && int'(wb_addr) == a) return wb_data;
    return m_regs[a];
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // One clock: drive inputs, predict, advance.
  task automatic step(input logic v, input logic [0:31] ins,
                      input logic wbe, input int wba, input logic [63:0] wbd,
                      input logic fe, input int fa, input logic [63:0] fd,
                      input logic rdy);
    bit   exp_ready;
    exp_t e;
    int   op;
    int   fn;
    if_valid = v; if_instr = ins;
    wb_en = wbe; wb_addr = wba[4:0]; wb_data = wbd;
    fwd_en = fe; fwd_addr = fa[4:0]; fwd_data = fd;
    ex_ready = rdy;
    #1;
    exp_ready = !m_valid || rdy;
    check("if_ready", {255'd0, if_ready}, {255'd0, exp_ready});
    if (v && exp_ready) begin
      op = int'(ins[0:5]);
      fn = int'(ins[26:31]);
      e.unit = 2'd0; e.shift = 2'd0; e.ww = 2'd0; e.func = 6'd0;
      e.rd = 5'd0; e.wr = 1'b0;
      if (op == 42) begin
        e.ww = ins[24:25]; e.func = fn[5:0]; e.rd = ins[6:10]; e.wr = 1'b1;
        if (fn >= 1 && fn <= 4) begin
          e.unit = 2'd1;
          e.shift = 2'(fn - 1);
        end else begin
          e.unit = 2'd2;
        end
      end else if (op != 0) begin
        m_illegal = 1'b1;
      end
      e.ra  = src_val(int'(ins[11:15]));
      e.rb  = src_val(int'(ins[16:20]));
      e.ill = m_illegal;
      exp_q.push_back(e);
    end
    if (exp_ready) m_valid = v;
    if (wbe) m_regs[wba] = wbd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b0, 0, 64'd0, 1'b0, 0, 64'd0, 1'b1);
  endtask

  // Synchronous reset cycle, optionally with a (to be ignored) writeback.
  task automatic do_reset(input logic wbe, input int wba, input logic [63:0] wbd);
    in_reset = 1'b1;
    reset = 1'b1;
    wb_en = wbe; wb_addr = wba[4:0]; wb_data = wbd;
    ex_ready = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    wb_en = 1'b0;
    for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
    m_valid = 1'b0;
    m_illegal = 1'b0;
    check("reset_flags", {253'd0, ex_valid, illegal, if_ready}, {253'd0, 3'b001});
    check("reset_fields", {ex_unit, ex_shift, ex_ww, ex_func, ex_ra, ex_rb, ex_rd, ex_wr_en},
          256'd0);
    in_reset = 1'b0;
  endtask

  // Monitor: compare whenever the stage presents an op; pop on handshake.
  always @(negedge clk) begin
    if (!in_reset && ex_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_valid: ex_valid=1 with no op expected");
      end else begin
        check("issue", {ex_unit, ex_shift, ex_ww, ex_func, ex_ra, ex_rb, ex_rd, ex_wr_en, illegal},
              {exp_q[0].unit, exp_q[0].shift, exp_q[0].ww, exp_q[0].func, exp_q[0].ra,
               exp_q[0].rb, exp_q[0].rd, exp_q[0].wr, exp_q[0].ill});
        if (ex_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [0:31] ins;
    int          a;
    for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
    @(posedge clk);
    #1;
    do_reset(1'b0, 0, 64'd0);

    // Writes, then SLL double r3 = r1 << r2
    step(1'b0, 32'd0, 1'b1, 1, 64'h0123456789ABCDEF, 1'b0, 0, 64'd0, 1'b1);
    step(1'b0, 32'd0, 1'b1, 2, 64'h0000000000000004, 1'b0, 0, 64'd0, 1'b1);
    step(1'b1, mk(42, 3, 1, 2, 3, 1), 1'b0, 0, 64'd0, 1'b0, 0, 64'd0, 1'b1);
    idle(1);

    // Forwarding beats same-cycle writeback; then writeback alone
    step(1'b1, mk(42, 4, 1, 2, 2, 1), 1'b1, 1, 64'h1234, 1'b1, 1, 64'hFFFF, 1'b1);
    step(1'b1, mk(42, 4, 1, 2, 2, 1), 1'b1, 1, 64'h1234, 1'b0, 0, 64'd0, 1'b1);
    step(1'b1, mk(42, 5, 1, 1, 1, 2), 1'b0, 0, 64'd0, 1'b0, 0, 64'd0, 1'b1);
    idle(1);

    // Backpressure: three stalled cycles (with a wb that must still commit)
    step(1'b1, mk(42, 6, 2, 1, 0, 3), 1'b0, 0, 64'd0, 1'b0, 0, 64'd0, 1'b1);
    step(1'b1, mk(42, 7, 9, 2, 1, 4), 1'b1, 9, 64'hA5A5, 1'b0, 0, 64'd0, 1'b0);
    step(1'b1, mk(42, 7, 9, 2, 1, 4), 1'b0, 0, 64'd0, 1'b0, 0, 64'd0, 1'b0);
    step(1'b1, mk(42, 7, 9, 2, 1, 4), 1'b0, 0, 64'd0, 1'b0, 0, 64'd0, 1'b0);
    step(1'b1, mk(42, 7, 9, 2, 1, 4), 1'b0, 0, 64'd0, 1'b0, 0, 64'd0, 1'b1);
    step(1'b1, mk(42, 8, 0, 9, 3, 33), 1'b0, 0, 64'd0, 1'b0, 0, 64'd0, 1'b1);
    idle(2);

    // Illegal opcode, sticky across later legal ops
    step(1'b1, mk(63, 3, 1, 2, 3, 1), 1'b0, 0, 64'd0, 1'b0, 0, 64'd0, 1'b1);
    step(1'b1, mk(42, 3, 1, 2, 3, 1), 1'b0, 0, 64'd0, 1'b0, 0, 64'd0, 1'b1);
    step(1'b1, mk(0, 0, 1, 2, 0, 0), 1'b0, 0, 64'd0, 1'b0, 0, 64'd0, 1'b1);
    idle(1);

    // Reset with a stalled op and a writeback during the reset cycle
    step(1'b1, mk(42, 3, 1, 2, 3, 1), 1'b0, 0, 64'd0, 1'b0, 0, 64'd0, 1'b0);
    step(1'b1, mk(42, 3, 5, 1, 3, 1), 1'b0, 0, 64'd0, 1'b0, 0, 64'd0, 1'b0);
    do_reset(1'b1, 5, 64'hDEAD);
    step(1'b1, mk(42, 3, 5, 1, 3, 1), 1'b0, 0, 64'd0, 1'b0, 0, 64'd0, 1'b1);
    step(1'b1, mk(42, 3, 9, 2, 3, 7), 1'b0, 0, 64'd0, 1'b0, 0, 64'd0, 1'b1);
    idle(2);

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      a = $urandom_range(0, 39);
      if (a == 0) ins = mk($urandom_range(1, 63), $urandom, $urandom, $urandom, $urandom, $urandom);
      else if (a < 5) ins = mk(0, $urandom, $urandom, $urandom, $urandom, $urandom);
      else ins = mk(($urandom_range(0, 20) == 0) ? 42 + 1 : 42,
                    $urandom_range(0, 31),
                    ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 3),
                    ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 3),
                    $urandom_range(0, 3),
                    ($urandom_range(0, 1) == 0) ? $urandom_range(0, 5) : $urandom_range(0, 63));
      ins[21:23] = 3'($urandom);
      step($urandom_range(0, 3) != 0, ins,
           $urandom_range(0, 1) == 1, $urandom_range(0, 3), {$urandom, $urandom},
           $urandom_range(0, 2) == 0, $urandom_range(0, 3), {$urandom, $urandom},
           $urandom_range(0, 3) != 0);
      if (k == 1500) do_reset($urandom_range(0, 1) == 1, $urandom_range(0, 3), {$urandom, $urandom});
    end
    idle(4);

    check("drained", {224'd0, 32'(exp_q.size())}, 256'd0);
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/simd_decode_issue.md
Name: simd_decode_issue

Overview:
- Decode/issue stage directly upstream of the SIMD shifter/ALU execute stage.
- Accepts 32-bit instructions from fetch over a valid/ready handshake and decodes the shift/ww/function fields.
- Reads operands from an internal 32x64 register file, with forwarding from the execute result and the writeback port.
- Registers everything into an ID/EX pipeline register that drives the shifter's shift, ra, rb and ww inputs.

Parameters:
- DATA_W, 64, operand width; fixed at 64 because of big-endian [0:63] lane slicing.
- NREG, 32, register file depth.
- AW, 5, register address width.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high.
- if_valid  input  1  fetch presents an instruction.
- if_ready  output  1  stage can accept; combinational = !ex_valid | ex_ready.
- if_instr  input  [0:31]  instruction word, bit 0 = MSB.
- wb_en  input  1  writeback write enable.
- wb_addr  input  [0:4]  writeback register.
- wb_data  input  [0:63]  writeback data.
- fwd_en  input  1  execute stage holds a valid result-producing op.
- fwd_addr  input  [0:4]  destination of that op.
- fwd_data  input  [0:63]  its combinational result.
- ex_ready  input  1  execute stage accepts.
- ex_valid  output  1  ID/EX register holds a valid op.
- ex_unit  output  [0:1]  00 nop, 01 shifter, 10 alu.
- ex_shift  output  [0:1]  00 SLL, 01 SRL, 10 SRA, 11 RTTH.
- ex_ww  output  [0:1]  00 byte, 01 half, 10 word, 11 double.
- ex_func  output  [0:5]  raw function field for the ALU.
- ex_ra  output  [0:63]  first operand.
- ex_rb  output  [0:63]  second operand / per-lane shift amounts.
- ex_rd  output  [0:4]  destination register.
- ex_wr_en  output  1  op writes rd.
- illegal  output  1  sticky; set on an undefined opcode.

Behaviour:
- Instruction fields: opcode [0:5], rd [6:10], ra [11:15], rb [16:20], ww [24:25], func [26:31].
- Opcode 000000 = NOP: unit 00, wr_en 0.
- Opcode 101010 = R-type:
  - func 000001..000100 -> unit 01 with shift = func[4:5]-1 (SLL, SRL, SRA, RTTH).
  - Any other func -> unit 10, func passed through.
  - wr_en 1.
- Any other opcode -> illegal; issued as NOP (unit 00, wr_en 0); illegal set and held until reset.
- Accept condition: if_valid & if_ready.
  - On accept, the ID/EX register loads the decoded fields and operands; ex_valid=1 next cycle.
  - If if_ready & !if_valid, ex_valid clears.
  - If !if_ready, the ID/EX register holds all outputs stable.
- Issue latency: one cycle from accept to ex_valid.
- Operand selection, per source, at accept, in priority order:
  1. fwd_en & fwd_addr==src -> fwd_data.
  2. wb_en & wb_addr==src -> wb_data (write-through bypass).
  3. Register file contents.
- r0 is an ordinary register; it is not hardwired to zero.
- Register file: written on a rising edge when wb_en=1. A wb write that coincides with a stall still commits.
- Same-cycle wb and fwd to the same source: the fwd value wins.
- Reset:
  - ex_valid, illegal and ex_wr_en = 0; all other outputs = 0.
  - All 32 registers cleared to 0.
  - if_ready = 1 in the first cycle after reset.
- Reset mid-stall: the held op is discarded and no writeback is lost beyond the reset cycle; a wb_en asserted during the reset cycle is ignored.
- No X propagation: unused ex_ww/ex_shift drive 0 for NOP and illegal ops.

Decomposition:
- Shared package simd_isa_pkg holds:
  - Opcode constants OP_NOP and OP_RTYPE.
  - Func constants F_SLL, F_SRL, F_SRA, F_RTTH.
  - Unit encodings UNIT_NOP, UNIT_SHF, UNIT_ALU.
  - Shift and ww encodings.
- Sub-module simd_regfile: 32x64, two combinational read ports with write-through bypass, one write port, synchronous reset.
- Decode, forwarding and the pipeline register stay in the top module.

Test Plan:
- Write r1=0x0123456789ABCDEF and r2=0x0000000000000004 via wb. Issue SLL (opcode 101010, func 000001, ww=11, rd=3, ra=1, rb=2) -> next cycle: ex_valid=1, ex_unit=01, ex_shift=00, ex_ww=11, ex_ra=0x0123456789ABCDEF, ex_rb=0x4, ex_rd=3, ex_wr_en=1.
- Forwarding: fwd_en=1, fwd_addr=1, fwd_data=0xFFFF, plus a same-cycle wb to r1 of 0x1234; issue with ra=1 -> ex_ra=0xFFFF. Repeat with fwd_en=0 -> ex_ra=0x1234.
- Backpressure: ex_ready=0 for 3 cycles while if_valid=1 -> if_ready=0 and outputs held constant. Drive ex_ready=1 -> next instruction is issued in the following cycle, with no duplication or loss.
- Illegal opcode 111111 -> ex_valid=1, ex_unit=00, ex_wr_en=0, illegal=1; illegal remains 1 after later legal ops until reset.
- Reset with ex_valid=1 and a stalled op -> next cycle: ex_valid=0, illegal=0, if_ready=1; reading any register afterwards returns 0.
- Bubbles: if_valid=0 with ex_ready=1 -> ex_valid drops to 0 one cycle after the last accept.
